pb_conditioner: RTL and testbench

Input conditioner between the DE10 board's raw push-buttons and slide switches and the user logic of a test design. It synchronizes asynchronous `PB` and `SW` inputs into `CLK`, debounces each active-low push-button, and emits clean level, press-pulse and release-pulse outputs. It is the board-input counterpart of the LED and seven-segment output path: it consumes the same `PB` and `SW` stimulus that the bench drives.

---
 rtl/pb_conditioner.sv | 259 +++++++++++++++++++++++++
 tb/tb_pb_conditioner.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pb_conditioner.sv
// -----------------------------------------------------------------------------
// pb_conditioner
//
// Conditions the DE10 board's raw push-buttons and slide switches for user
// logic clocked by CLK. Every PB and SW bit is brought into the CLK domain
// through a two-flop synchronizer. Each active-low push-button is then
// debounced by its own four-state FSM, which produces a clean level plus
// one-cycle press and release pulses.
//
// Optional feature macro: PB_CONDITIONER_REPEAT_EN
//   When defined, a button held in the debounced "pressed" state produces
//   extra pb_press pulses. The first comes REPEAT_DELAY cycles after the
//   press pulse, and the rest follow every REPEAT_PERIOD cycles. When the
//   macro is undefined, no repeat logic is built and the REPEAT_*
//   parameters have no effect.
//
// Parameters:
//   PB_W            number of push-buttons
//   SW_W            number of slide switches
//   DEBOUNCE_CYCLES consecutive stable synchronized samples needed to accept
//                   a change (must be >= 1)
//   REPEAT_DELAY    cycles from a press pulse to the first auto-repeat pulse
//   REPEAT_PERIOD   cycles between later auto-repeat pulses (must be >= 1)
//
// Ports:
//   CLK         in   1     system clock; the only clock
//   RST         in   1     synchronous reset, active-high
//   PB          in   PB_W  raw push-buttons, active-low, asynchronous
//   SW          in   SW_W  raw switches, asynchronous
//   pb_level    out  PB_W  debounced state, 1 = pressed
//   pb_press    out  PB_W  one-cycle pulse per accepted press (and repeat)
//   pb_release  out  PB_W  one-cycle pulse per accepted release
//   sw_sync     out  SW_W  synchronized switches (no debounce)
// -----------------------------------------------------------------------------
module pb_conditioner #(
    parameter int PB_W            = 4,
    parameter int SW_W            = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [PB_W-1:0] PB,
    input  logic [SW_W-1:0] SW,
    output logic [PB_W-1:0] pb_level,
    output logic [PB_W-1:0] pb_press,
    output logic [PB_W-1:0] pb_release,
    output logic [SW_W-1:0] sw_sync
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } pb_state_t;

    logic [PB_W-1:0] pb_meta_r;
    logic [PB_W-1:0] pb_sync_r;
    logic [SW_W-1:0] sw_meta_r;
    logic [SW_W-1:0] sw_sync_r;

    // Two-flop synchronizers; buttons reset to "released" (1), switches to 0.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pb_meta_r <= '1;
            pb_sync_r <= '1;
            sw_meta_r <= '0;
            sw_sync_r <= '0;
        end else begin
            pb_meta_r <= PB;
            pb_sync_r <= pb_meta_r;
            sw_meta_r <= SW;
            sw_sync_r <= sw_meta_r;
        end
    end

    assign sw_sync = sw_sync_r;

    for (genvar g = 0; g < PB_W; g++) begin : g_btn
        pb_state_t        state_r;
        pb_state_t        state_s;
        logic [DEB_W-1:0] cnt_r;
        logic [DEB_W-1:0] cnt_s;
        logic [DEB_W-1:0] cnt_inc_s;
        logic             pressed_s;
        logic             accept_press_s;
        logic             accept_release_s;
        logic             rpt_fire_s;
        logic             level_r;
        logic             level_s;
        logic             press_r;
        logic             press_s;
        logic             release_r;
        logic             release_s;

        // Synchronized PB is active-low; cnt_inc_s never exceeds DEB_MAX.
        assign pressed_s = ~pb_sync_r[g];
        assign cnt_inc_s = cnt_r + DEB_W'(1);

        // State, debounce counter and registered outputs.
        always_ff @(posedge CLK) begin
            if (RST) begin
                state_r   <= ST_RELEASED;
                cnt_r     <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
            end else begin
                state_r   <= state_s;
                cnt_r     <= cnt_s;
                level_r   <= level_s;
                press_r   <= press_s;
                release_r <= release_s;
            end
        end

        // Next-state logic. The count a state is entered with already
        // includes the sample that caused the entry, so DEBOUNCE_CYCLES=1
        // accepts directly from the stable state.
        always_comb begin
            state_s = state_r;
            cnt_s   = cnt_r;
            case (state_r)
                ST_RELEASED: begin
                    if (pressed_s) begin
                        if (DEB_ONE == DEB_MAX) begin
                            state_s = ST_HELD;
                            cnt_s   = '0;
                        end else begin
                            state_s = ST_PRESS_CHK;
                            cnt_s   = DEB_ONE;
                        end
                    end else begin
                        cnt_s = '0;
                    end
                end
                ST_PRESS_CHK: begin
                    if (pressed_s) begin
                        if (cnt_inc_s == DEB_MAX) begin
                            state_s = ST_HELD;
                            cnt_s   = '0;
                        end else begin
                            cnt_s = cnt_inc_s;
                        end
                    end else begin
                        state_s = ST_RELEASED;
                        cnt_s   = '0;
                    end
                end
                ST_HELD: begin
                    if (!pressed_s) begin
                        if (DEB_ONE == DEB_MAX) begin
                            state_s = ST_RELEASED;
                            cnt_s   = '0;
                        end else begin
                            state_s = ST_REL_CHK;
                            cnt_s   = DEB_ONE;
                        end
                    end else begin
                        cnt_s = '0;
                    end
                end
                ST_REL_CHK: begin
                    if (!pressed_s) begin
                        if (cnt_inc_s == DEB_MAX) begin
                            state_s = ST_RELEASED;
                            cnt_s   = '0;
                        end else begin
                            cnt_s = cnt_inc_s;
                        end
                    end else begin
                        state_s = ST_HELD;
                        cnt_s   = '0;
                    end
                end
                default: begin
                    state_s = ST_RELEASED;
                    cnt_s   = '0;
                end
            endcase
        end

        // Output logic: accepted transitions and repeats become next-cycle pulses.
        always_comb begin
            accept_press_s   = (state_r inside {ST_RELEASED, ST_PRESS_CHK}) &&
                               (state_s == ST_HELD);
            accept_release_s = (state_r inside {ST_HELD, ST_REL_CHK}) &&
                               (state_s == ST_RELEASED);
            level_s          = (state_s == ST_HELD) || (state_s == ST_REL_CHK);
            press_s          = accept_press_s | rpt_fire_s;
            release_s        = accept_release_s;
        end

`ifdef PB_CONDITIONER_REPEAT_EN
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RPT_W   = $clog2(RPT_MAX + 1);
        localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
        localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);

        logic [RPT_W-1:0] rpt_cnt_r;
        logic [RPT_W-1:0] rpt_cnt_s;
        logic [RPT_W-1:0] rpt_inc_s;
        logic             rpt_started_r;
        logic             rpt_started_s;

        assign rpt_inc_s = rpt_cnt_r + RPT_W'(1);

        // Repeat counter and "first repeat already fired" flag.
        always_ff @(posedge CLK) begin
            if (RST) begin
                rpt_cnt_r     <= '0;
                rpt_started_r <= 1'b0;
            end else begin
                rpt_cnt_r     <= rpt_cnt_s;
                rpt_started_r <= rpt_started_s;
            end
        end

        // The counter runs only across HELD-to-HELD cycles, so it holds
        // through a REL_CHK bounce. A new press or an accepted release
        // restarts it.
        always_comb begin
            rpt_cnt_s     = rpt_cnt_r;
            rpt_started_s = rpt_started_r;
            rpt_fire_s    = 1'b0;
            if (accept_press_s || (state_s == ST_RELEASED)) begin
                rpt_cnt_s     = '0;
                rpt_started_s = 1'b0;
            end else if ((state_r == ST_HELD) && (state_s == ST_HELD)) begin
                if (!rpt_started_r && (rpt_inc_s == RPT_DELAY_V)) begin
                    rpt_fire_s    = 1'b1;
                    rpt_cnt_s     = '0;
                    rpt_started_s = 1'b1;
                end else if (rpt_started_r && (rpt_inc_s == RPT_PERIOD_V)) begin
                    rpt_fire_s = 1'b1;
                    rpt_cnt_s  = '0;
                end else begin
                    rpt_cnt_s = rpt_inc_s;
                end
            end else begin
                rpt_cnt_s = rpt_cnt_r;
            end
        end
`else
        assign rpt_fire_s = 1'b0;
`endif

        assign pb_level[g]   = level_r;
        assign pb_press[g]   = press_r;
        assign pb_release[g] = release_r;
    end

endmodule

// File: tb/tb_pb_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pb_conditioner
//
// Directed self-checking bench for pb_conditioner. It runs with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=10 and REPEAT_PERIOD=5. Inputs change 1
// time unit after a rising edge, so the next rising edge is "edge N".
// Outputs are sampled 1 time unit after the edge being checked.
// -----------------------------------------------------------------------------
module tb_pb_conditioner;

`ifdef PB_CONDITIONER_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] pb;
    logic [9:0] sw;
    logic [3:0] pb_level;
    logic [3:0] pb_press;
    logic [3:0] pb_release;
    logic [9:0] sw_sync;

    int vectors     = 0;
    int miscompares = 0;

    pb_conditioner #(
        .PB_W            (4),
        .SW_W            (10),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .PB         (pb),
        .SW         (sw),
        .pb_level   (pb_level),
        .pb_press   (pb_press),
        .pb_release (pb_release),
        .sw_sync    (sw_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bit pat [0:7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        // 1. Reset
        rst = 1'b1;
        pb  = 4'hF;
        sw  = 10'h000;
        tick(2);
        chk("rst_level",   {12'h000, pb_level},   16'h0000);
        chk("rst_press",   {12'h000, pb_press},   16'h0000);
        chk("rst_release", {12'h000, pb_release}, 16'h0000);
        chk("rst_sw",      {6'h00, sw_sync},      16'h0000);
        rst = 1'b0;
        sw  = 10'h2A5;
        tick(1);
        chk("sw_after_N",  {6'h00, sw_sync}, 16'h0000);
        tick(1);
        chk("sw_after_N1", {6'h00, sw_sync}, 16'h02A5);

        // 2. Clean press of PB[0]
        pb = 4'b1110;
        tick(5);
        chk("press0_N4_level", {12'h000, pb_level}, 16'h0000);
        chk("press0_N4_press", {12'h000, pb_press}, 16'h0000);
        tick(1);
        chk("press0_N5_level",   {12'h000, pb_level},   16'h0001);
        chk("press0_N5_press",   {12'h000, pb_press},   16'h0001);
        chk("press0_N5_release", {12'h000, pb_release}, 16'h0000);
        tick(1);
        chk("press0_N6_press", {12'h000, pb_press}, 16'h0000);
        chk("press0_N6_level", {12'h000, pb_level}, 16'h0001);

        // 6. Auto-repeat: currently after edge E+1 (E = press-accept edge)
        for (int k = 2; k <= 29; k++) begin
            tick(1);
            chk($sformatf("repeat_k%0d", k), {15'h0000, pb_press[0]},
                {15'h0000, REP && (k == 10 || k == 15 || k == 20 || k == 25)});
        end

        // 3. Bounce rejection on PB[1]
        for (int i = 0; i < 8; i++) begin
            pb[1] = pat[i];
            tick(1);
            chk($sformatf("bounce_press_%0d", i), {15'h0000, pb_press[1]}, 16'h0000);
            chk($sformatf("bounce_level_%0d", i), {15'h0000, pb_level[1]}, 16'h0000);
        end
        pb[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk($sformatf("bounce_tail_%0d", i), {14'h0000, pb_level[1], pb_press[1]}, 16'h0000);
        end

        // 4. Release PB[0] and press PB[2], PB[3] at the same edge
        pb = 4'b0011;
        tick(5);
        chk("simul_N4_release", {12'h000, pb_release}, 16'h0000);
        chk("simul_N4_press",   {12'h000, pb_press},   16'h0000);
        chk("simul_N4_level",   {12'h000, pb_level},   16'h0001);
        tick(1);
        chk("simul_N5_release", {12'h000, pb_release}, 16'h0001);
        chk("simul_N5_press",   {12'h000, pb_press},   16'h000C);
        chk("simul_N5_level",   {12'h000, pb_level},   16'h000C);
        tick(1);
        chk("simul_N6_release", {12'h000, pb_release}, 16'h0000);
        chk("simul_N6_press",   {12'h000, pb_press},   16'h0000);

        // Release everything before the reset test
        pb = 4'hF;
        tick(6);
        chk("relall_release", {12'h000, pb_release}, 16'h000C);
        chk("relall_level",   {12'h000, pb_level},   16'h0000);
        tick(2);

        // 5. Reset mid-debounce on PB[3]
        pb = 4'b0111;
        tick(3);
        chk("rstmid_pre_press", {12'h000, pb_press}, 16'h0000);
        chk("rstmid_pre_level", {12'h000, pb_level}, 16'h0000);
        rst = 1'b1;
        tick(1);
        chk("rstmid_in_level", {12'h000, pb_level}, 16'h0000);
        chk("rstmid_in_press", {12'h000, pb_press}, 16'h0000);
        rst = 1'b0;
        tick(5);
        chk("rstmid_R4_press", {15'h0000, pb_press[3]}, 16'h0000);
        tick(1);
        chk("rstmid_R5_press", {12'h000, pb_press}, 16'h0008);
        chk("rstmid_R5_level", {12'h000, pb_level}, 16'h0008);
        tick(1);
        chk("rstmid_R6_press", {12'h000, pb_press}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
